tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- 1-to-4 time-division demultiplexer; the receive-side counterpart of the 4:1 mux, which merges four channels onto one line.
- Accepts a beat stream on one input, where a frame is 4 beats and beat 0 is marked by in_sync.
- Steers each beat into one of four registered channel outputs and pulses the matching per-channel valid.
- Sits between the shared line and the per-channel consumers.

Parameters:
- WIDTH, 1, data width of the input beat and of each channel output.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  beat data.
- in_valid  input  1  beat present this cycle.
- in_sync  input  1  marks the slot-0 beat; ignored when in_valid=0.
- output1..output4  output  WIDTH each  channel data registers (slots 0..3).
- out_valid  output  4  one-cycle strobe per channel; bit n = channel n+1.
- select1  output  1  MSB of the slot last written.
- select2  output  1  LSB of the slot last written.
- frame_done  output  1  one-cycle pulse when the slot-3 beat is captured.
- locked  output  1  high while in state LOCKED.
- sync_err  output  1  one-cycle pulse on any framing violation.
- err_count  output  8  framing-error counter (see Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous):
  - output1..4 = 0, out_valid = 0, select1/select2 = 0.
  - frame_done = 0, sync_err = 0, locked = 0, err_count = 0.
  - slot counter = 0, state = HUNT.
- Latency: a beat sampled at edge k appears on outputN/out_valid/select*/frame_done immediately after edge k (1 register stage). Strobes are high for exactly one cycle.
- in_valid=0 cycle:
  - no state change.
  - channel outputs hold; all strobes low.
- State HUNT:
  - in_valid & !in_sync: beat discarded; no strobes; no sync_err.
  - in_valid & in_sync: capture into output1, out_valid=0001, select=00, slot←1, state→LOCKED.
- State LOCKED, in_valid=1, slot 1..3:
  - !in_sync: write in_data to output(slot+1), set out_valid bit slot, select={slot[1],slot[0]}.
  - slot 3 additionally pulses frame_done; slot wraps 3→0.
- State LOCKED, in_valid=1, in_sync=1 while slot≠0 (early sync):
  - realign: beat treated as slot 0 → output1, out_valid=0001, slot←1.
  - sync_err pulses; remain LOCKED.
  - No frame_done for the truncated frame.
- State LOCKED, in_valid=1, slot=0:
  - in_sync=1: normal capture to output1, slot←1.
  - in_sync=0 (missing sync): beat discarded, no out_valid, sync_err pulses, state→HUNT, slot←0, locked falls.
- Only the addressed channel register changes; the other three hold their values.
- Reset mid-frame: immediate return to reset values; the partial frame is lost; the next frame must begin with in_sync.

Optional Feature:
- Macro: TDM_DEMUX_ERRCNT_EN.
- Defined:
  - err_count increments by 1 on every sync_err pulse and saturates at 255 (no wrap).
  - Cleared only by reset.
- Undefined:
  - err_count is tied to 8'd0; no counter flops are synthesised.
  - sync_err behaviour is unchanged.

Test Plan:
- Reset, then in_valid=0 for 5 cycles → all outputs 0, locked=0, no strobes.
- WIDTH=8; frame {sync,A5},{3C},{F0},{0F} on consecutive cycles:
  - output1..4 = A5/3C/F0/0F.
  - out_valid = 0001, 0010, 0100, 1000.
  - select = 00, 01, 10, 11.
  - frame_done on the 4th beat; locked=1 from the 1st.
- While in HUNT, beats 11, 22 without sync, then {sync,33}:
  - the first two beats are discarded (no strobes, sync_err=0).
  - 33 lands in output1, locked rises.
- While LOCKED, after two beats of a frame, {sync,77}:
  - sync_err pulses, output1=77, out_valid=0001.
  - the next beat goes to output2; no frame_done for the truncated frame.
- While LOCKED, slot-0 beat 99 without sync:
  - sync_err pulses, locked=0, output1 unchanged, no out_valid.
  - With TDM_DEMUX_ERRCNT_EN: err_count=1, and saturates at 255 after 300 forced errors. Without it: err_count stays 0.
- Gaps plus reset: in_valid=0 gaps of 1–3 cycles inside a frame keep the slot order and no strobes occur during gaps; reset_n asserted after beat 2 clears all outputs within the same cycle, and the next frame resumes correctly from sync.

Source files
------------

// File: rtl/tdm_demux4.sv
// 1-to-4 time-division demultiplexer: steers each beat of a 4-beat frame into a registered channel output.
// Optional framing-error counter enabled by defining TDM_DEMUX_ERRCNT_EN.
module tdm_demux4 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_sync,
   output logic [WIDTH-1:0] output1,
   output logic [WIDTH-1:0] output2,
   output logic [WIDTH-1:0] output3,
   output logic [WIDTH-1:0] output4,
   output logic [3:0]       out_valid,
   output logic             select1,
   output logic             select2,
   output logic             frame_done,
   output logic             locked,
   output logic             sync_err,
   output logic [7:0]       err_count
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] slot;
   logic [1:0] slot_nxt;

   logic [3:0] vld_p0;
   logic [1:0] sel_p0;
   logic       done_p0;
   logic       err_p0;

   // stage 0: decode the incoming beat against the framing state
   always_comb begin
      state_nxt = state;
      slot_nxt  = slot;
      vld_p0    = 4'b0000;
      sel_p0    = {select1, select2};
      done_p0   = 1'b0;
      err_p0    = 1'b0;
      if (in_valid) begin
         case (state)
            HUNT: begin
               if (in_sync) begin
                  vld_p0    = 4'b0001;
                  sel_p0    = 2'd0;
                  slot_nxt  = 2'd1;
                  state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               if (in_sync) begin
                  // a sync always realigns to slot 0; early ones are flagged
                  vld_p0   = 4'b0001;
                  sel_p0   = 2'd0;
                  slot_nxt = 2'd1;
                  err_p0   = (slot != 2'd0);
               end else if (slot == 2'd0) begin
                  err_p0    = 1'b1;
                  slot_nxt  = 2'd0;
                  state_nxt = HUNT;
               end else begin
                  vld_p0   = 4'b0001 << slot;
                  sel_p0   = slot;
                  slot_nxt = slot + 2'd1;
                  done_p0  = (slot == 2'd3);
               end
            end
            default: begin
               state_nxt = HUNT;
               slot_nxt  = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= HUNT;
         slot  <= 2'd0;
      end else begin
         state <= state_nxt;
         slot  <= slot_nxt;
      end
   end

   // stage 1: registered channel data and strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         output1    <= '0;
         output2    <= '0;
         output3    <= '0;
         output4    <= '0;
         out_valid  <= 4'b0000;
         select1    <= 1'b0;
         select2    <= 1'b0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         if (vld_p0[0]) output1 <= in_data;
         if (vld_p0[1]) output2 <= in_data;
         if (vld_p0[2]) output3 <= in_data;
         if (vld_p0[3]) output4 <= in_data;
         out_valid  <= vld_p0;
         select1    <= sel_p0[1];
         select2    <= sel_p0[0];
         frame_done <= done_p0;
         sync_err   <= err_p0;
      end
   end

   assign locked = (state == LOCKED);

`ifdef TDM_DEMUX_ERRCNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [7:0] err_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt_q <= 8'd0;
      end else if (err_p0) begin
         err_cnt_q <= sat_inc8(err_cnt_q);
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: directed beats push expected strobe events, a monitor pops and compares.
module tb_tdm_demux4;

   logic       clk;
   logic       reset_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_sync;
   logic [7:0] output1, output2, output3, output4;
   logic [3:0] out_valid;
   logic       select1, select2, frame_done, locked, sync_err;
   logic [7:0] err_count;

   typedef struct packed {
      logic [3:0] vld;
      logic [7:0] data;
      logic [1:0] sel;
      logic       fd;
      logic       err;
      logic       lck;
   } exp_t;

   exp_t q[$];
   int   tests;
   int   failed;
   int   errs;

   tdm_demux4 #(.WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_sync(in_sync),
      .output1(output1), .output2(output2), .output3(output3), .output4(output4),
      .out_valid(out_valid), .select1(select1), .select2(select2), .frame_done(frame_done),
      .locked(locked), .sync_err(sync_err), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] exp_cnt(input int n);
`ifdef TDM_DEMUX_ERRCNT_EN
      return (n > 255) ? 8'd255 : n[7:0];
`else
      return 8'd0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // called at a negedge; returns at the next negedge after the beat was sampled
   task automatic beat(input logic s, input logic [7:0] d, input logic [3:0] evld,
                       input logic [7:0] edata, input logic [1:0] esel, input logic efd,
                       input logic eerr, input logic elck);
      exp_t e;
      if (evld != 4'b0000 || efd || eerr) begin
         e.vld = evld; e.data = edata; e.sel = esel; e.fd = efd; e.err = eerr; e.lck = elck;
         q.push_back(e);
      end
      if (eerr) errs++;
      in_valid = 1'b1;
      in_sync  = s;
      in_data  = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sync  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // monitor: any strobe must match the oldest expected event
   always @(posedge clk) begin
      #1;
      if (out_valid != 4'b0000 || frame_done || sync_err) begin
         tests++;
         if (q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_event: vld=%b fd=%b err=%b, nothing expected",
                     out_valid, frame_done, sync_err);
         end else begin
            exp_t e;
            logic [7:0] gd;
            e = q.pop_front();
            case (e.vld)
               4'b0010: gd = output2;
               4'b0100: gd = output3;
               4'b1000: gd = output4;
               default: gd = output1;
            endcase
            if (out_valid !== e.vld || gd !== e.data || {select1, select2} !== e.sel ||
                frame_done !== e.fd || sync_err !== e.err || locked !== e.lck) begin
               failed++;
               $display("FAIL event: got vld=%b data=%h sel=%b fd=%b err=%b lck=%b expected vld=%b data=%h sel=%b fd=%b err=%b lck=%b",
                        out_valid, gd, {select1, select2}, frame_done, sync_err, locked,
                        e.vld, e.data, e.sel, e.fd, e.err, e.lck);
            end
         end
      end
   end

   initial begin
      tests = 0; failed = 0; errs = 0;
      reset_n = 1'b0; in_valid = 1'b0; in_sync = 1'b0; in_data = 8'h00;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      idle(5);
      chk("rst_out1", output1, 0);
      chk("rst_out4", output4, 0);
      chk("rst_vld", out_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_sel", {select1, select2}, 0);
      chk("rst_errcnt", err_count, 0);

      // basic frame
      beat(1, 8'hA5, 4'b0001, 8'hA5, 2'd0, 0, 0, 1);
      chk("lock_first", locked, 1);
      beat(0, 8'h3C, 4'b0010, 8'h3C, 2'd1, 0, 0, 1);
      beat(0, 8'hF0, 4'b0100, 8'hF0, 2'd2, 0, 0, 1);
      beat(0, 8'h0F, 4'b1000, 8'h0F, 2'd3, 1, 0, 1);
      chk("frame_out1", output1, 8'hA5);
      chk("frame_out2", output2, 8'h3C);
      chk("frame_out3", output3, 8'hF0);
      chk("frame_out4", output4, 8'h0F);

      // missing sync at slot 0
      beat(0, 8'h99, 4'b0000, 8'hA5, 2'd3, 0, 1, 0);
      chk("miss_locked", locked, 0);
      chk("miss_out1", output1, 8'hA5);
      chk("miss_errcnt", err_count, exp_cnt(errs));

      // hunt discards unsynced beats
      beat(0, 8'h11, 4'b0000, 8'h00, 2'd0, 0, 0, 0);
      beat(0, 8'h22, 4'b0000, 8'h00, 2'd0, 0, 0, 0);
      chk("hunt_locked", locked, 0);
      beat(1, 8'h33, 4'b0001, 8'h33, 2'd0, 0, 0, 1);

      // early sync realigns
      beat(0, 8'h44, 4'b0010, 8'h44, 2'd1, 0, 0, 1);
      beat(0, 8'h55, 4'b0100, 8'h55, 2'd2, 0, 0, 1);
      beat(1, 8'h77, 4'b0001, 8'h77, 2'd0, 0, 1, 1);
      beat(0, 8'h88, 4'b0010, 8'h88, 2'd1, 0, 0, 1);
      beat(0, 8'h66, 4'b0100, 8'h66, 2'd2, 0, 0, 1);
      beat(0, 8'hAA, 4'b1000, 8'hAA, 2'd3, 1, 0, 1);
      chk("hold_out1", output1, 8'h77);
      chk("hold_out2", output2, 8'h88);
      chk("hold_out3", output3, 8'h66);
      chk("early_errcnt", err_count, exp_cnt(errs));

      // gaps inside a frame
      beat(1, 8'hB0, 4'b0001, 8'hB0, 2'd0, 0, 0, 1);
      idle(1);
      beat(0, 8'hB1, 4'b0010, 8'hB1, 2'd1, 0, 0, 1);
      idle(3);
      beat(0, 8'hB2, 4'b0100, 8'hB2, 2'd2, 0, 0, 1);
      idle(2);
      beat(0, 8'hB3, 4'b1000, 8'hB3, 2'd3, 1, 0, 1);
      chk("gap_out4", output4, 8'hB3);

      // reset mid-frame
      beat(1, 8'hC0, 4'b0001, 8'hC0, 2'd0, 0, 0, 1);
      beat(0, 8'hC1, 4'b0010, 8'hC1, 2'd1, 0, 0, 1);
      beat(0, 8'hC2, 4'b0100, 8'hC2, 2'd2, 0, 0, 1);
      in_valid = 1'b0;
      in_sync  = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_out1", output1, 0);
      chk("mrst_out2", output2, 0);
      chk("mrst_out3", output3, 0);
      chk("mrst_out4", output4, 0);
      chk("mrst_locked", locked, 0);
      chk("mrst_sel", {select1, select2}, 0);
      chk("mrst_errcnt", err_count, 0);
      errs = 0;
      @(negedge clk);
      reset_n = 1'b1;
      beat(0, 8'hD9, 4'b0000, 8'h00, 2'd0, 0, 0, 0);
      beat(1, 8'hD0, 4'b0001, 8'hD0, 2'd0, 0, 0, 1);
      beat(0, 8'hD1, 4'b0010, 8'hD1, 2'd1, 0, 0, 1);
      beat(0, 8'hD2, 4'b0100, 8'hD2, 2'd2, 0, 0, 1);
      beat(0, 8'hD3, 4'b1000, 8'hD3, 2'd3, 1, 0, 1);

      // 300 early syncs drive the error counter to saturation
      beat(1, 8'hE0, 4'b0001, 8'hE0, 2'd0, 0, 0, 1);
      for (int i = 0; i < 300; i++) begin
         logic [7:0] d;
         d = 8'(i);
         beat(1, d, 4'b0001, d, 2'd0, 0, 1, 1);
      end
      chk("sat_errcnt", err_count, exp_cnt(errs));

      idle(3);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
